// File: rtl/mips_fetch_hazard_ctrl.sv
// mips_fetch_hazard_ctrl
// Pipeline sequencing controller for the 5-stage MIPS core. Arbitrates
// load-use stalls, ID-stage redirects (taken branch / jump) and a
// multi-cycle instruction memory with a ready handshake. It also tracks
// wrong-path fetches that are still outstanding when a redirect happens.
//
// Parameters:
//   WAIT_LIMIT    consecutive not-ready fetch cycles before FetchTimeout (1..255)
// Ports:
//   CLK, RST      clock; synchronous active-high reset
//   ID_EX_MemRead, ID_EX_Rt       load in EX and its destination register
//   IF_ID_Rs, IF_ID_Rt            source registers of the instruction in ID
//   BranchTaken, JumpID           redirect requests resolved in ID
//   IMemReady                     instruction memory returns a word this cycle
//   PCWrite, IF_IDWrite, IF_FLUSH, ID_EX_Bubble   combinational pipeline controls
//   CtrlState                     0 RUN, 1 WAIT, 2 DISCARD
//   FetchTimeout                  sticky fetch timeout flag
// Optional build macro:
//   HAZARD_PERF_CNT_EN            adds StallCount, FlushCount, WaitCount (16-bit, saturating)
module mips_fetch_hazard_ctrl #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rt,
  input  logic [4:0] IF_ID_Rs,
  input  logic [4:0] IF_ID_Rt,
  input  logic       BranchTaken,
  input  logic       JumpID,
  input  logic       IMemReady,
  output logic       PCWrite,
  output logic       IF_IDWrite,
  output logic       IF_FLUSH,
  output logic       ID_EX_Bubble,
  output logic [1:0] CtrlState,
  output logic       FetchTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount,
  output logic [15:0] WaitCount
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned PERF_W = 16;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]   w_wait_cnt_nxt;
  logic               r_timeout;
  logic               w_lu;
  logic               w_br;

  // Hazard detection: load in EX writing a register that ID reads
  always_comb begin
    w_lu = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
           ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));
    w_br = BranchTaken || JumpID;
  end

  // Next-state and control outputs; priority RST > LU > BR > fetch status
  always_comb begin
    w_state_nxt  = r_state;
    PCWrite      = 1'b0;
    IF_IDWrite   = 1'b1;
    IF_FLUSH     = 1'b0;
    ID_EX_Bubble = 1'b0;
    if (RST) begin
      IF_FLUSH     = 1'b1;
      ID_EX_Bubble = 1'b1;
      w_state_nxt  = ST_RUN;
    end else if (w_lu) begin
      // Freeze PC and IF/ID; a concurrent redirect is re-evaluated next cycle
      IF_IDWrite   = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (w_br) begin
      PCWrite     = 1'b1;
      IF_FLUSH    = 1'b1;
      // An unfinished fetch is wrong-path and must be drained before RUN
      w_state_nxt = IMemReady ? ST_RUN : ST_DISCARD;
    end else begin
      case (r_state)
        ST_RUN, ST_WAIT: begin
          if (IMemReady) begin
            PCWrite     = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            IF_FLUSH    = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
        ST_DISCARD: begin
          IF_FLUSH    = 1'b1;
          w_state_nxt = IMemReady ? ST_RUN : ST_DISCARD;
        end
        default: begin
          IF_FLUSH    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // Consecutive not-ready counter, saturating
  always_comb begin
    if (IMemReady) begin
      w_wait_cnt_nxt = '0;
    end else if (r_wait_cnt == {CNT_W{1'b1}}) begin
      w_wait_cnt_nxt = r_wait_cnt;
    end else begin
      w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
    end
  end

  // State register, wait counter and sticky timeout
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_wait_cnt_nxt == CNT_W'(WAIT_LIMIT)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign CtrlState    = r_state;
  assign FetchTimeout = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;
  logic [PERF_W-1:0] r_wait_perf;

  // Saturating performance counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_perf <= '0;
    end else begin
      if (w_lu && (r_stall_cnt != {PERF_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      end
      if (w_br && !w_lu && (r_flush_cnt != {PERF_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + PERF_W'(1);
      end
      if (!IMemReady && (r_wait_perf != {PERF_W{1'b1}})) begin
        r_wait_perf <= r_wait_perf + PERF_W'(1);
      end
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
  assign WaitCount  = r_wait_perf;
`endif

endmodule

// File: tb/tb_mips_fetch_hazard_ctrl.sv
// Testbench for mips_fetch_hazard_ctrl: per-cycle expected control outputs
// are queued when stimulus is applied and compared at the falling edge.
module tb_mips_fetch_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       mem_read;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       br_taken;
  logic       jump;
  logic       rdy;
  logic       pc_write;
  logic       ifid_write;
  logic       if_flush;
  logic       bubble;
  logic [1:0] ctrl_state;
  logic       timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
  logic [15:0] wait_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic       pcw;
    logic       ifidw;
    logic       flush;
    logic       bub;
    logic [1:0] st;
    logic       to;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];

  // Reference model state
  logic [1:0] m_state;
  int         m_cnt;
  logic       m_to;

  mips_fetch_hazard_ctrl #(.WAIT_LIMIT(15)) dut (
    .CLK          (clk),
    .RST          (rst),
    .ID_EX_MemRead(mem_read),
    .ID_EX_Rt     (ex_rt),
    .IF_ID_Rs     (id_rs),
    .IF_ID_Rt     (id_rt),
    .BranchTaken  (br_taken),
    .JumpID       (jump),
    .IMemReady    (rdy),
    .PCWrite      (pc_write),
    .IF_IDWrite   (ifid_write),
    .IF_FLUSH     (if_flush),
    .ID_EX_Bubble (bubble),
    .CtrlState    (ctrl_state),
    .FetchTimeout (timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount   (stall_count),
    .FlushCount   (flush_count),
    .WaitCount    (wait_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_lu();
    return mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

  // Expected combinational outputs for the currently applied inputs
  function automatic exp_t model_out();
    exp_t e;
    e.st = m_state;
    e.to = m_to;
    if (rst) begin
      {e.pcw, e.ifidw, e.flush, e.bub} = 4'b0111;
    end else if (model_lu()) begin
      {e.pcw, e.ifidw, e.flush, e.bub} = 4'b0001;
    end else if (br_taken || jump) begin
      {e.pcw, e.ifidw, e.flush, e.bub} = 4'b1110;
    end else if (m_state == 2'd2) begin
      {e.pcw, e.ifidw, e.flush, e.bub} = 4'b0110;
    end else if (rdy) begin
      {e.pcw, e.ifidw, e.flush, e.bub} = 4'b1100;
    end else begin
      {e.pcw, e.ifidw, e.flush, e.bub} = 4'b0110;
    end
    return e;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_state = 2'd0;
      m_cnt   = 0;
      m_to    = 1'b0;
    end else begin
      if (!model_lu()) begin
        if (br_taken || jump)  m_state = rdy ? 2'd0 : 2'd2;
        else if (rdy)          m_state = 2'd0;
        else if (m_state != 2'd2) m_state = 2'd1;
      end
      if (rdy) m_cnt = 0;
      else if (m_cnt < 255) m_cnt = m_cnt + 1;
      if (m_cnt == 15) m_to = 1'b1;
    end
  endtask

  // Apply one cycle of stimulus; returns one time unit after the rising edge
  task automatic drive(input string nm, input logic r, input logic mr,
                       input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] irt, input logic b, input logic j,
                       input logic rd);
    rst = r; mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = irt;
    br_taken = b; jump = j; rdy = rd;
    sb_q.push_back(model_out());
    name_q.push_back(nm);
    @(negedge clk);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input string nm, input logic rd);
    drive(nm, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, rd);
  endtask

  // Scoreboard compare at the falling edge
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = sb_q.pop_front();
      nm = name_q.pop_front();
      a  = {pc_write, ifid_write, if_flush, bubble, ctrl_state, timeout};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL %s at %0t: got pcw/ifidw/flush/bub/st/to=%b/%b/%b/%b/%0d/%b expected %b/%b/%b/%b/%0d/%b",
                 nm, $time, a.pcw, a.ifidw, a.flush, a.bub, a.st, a.to,
                 e.pcw, e.ifidw, e.flush, e.bub, e.st, e.to);
      end
    end
  end

  task automatic test_reset();
    drive("reset0", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive("reset1", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctrl_state !== 2'd0 || timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got st=%0d to=%b expected st=0 to=0", ctrl_state, timeout);
    end
  endtask

  task automatic test_load_use();
    drive("lu_stall", 1'b0, 1'b1, 5'd2, 5'd2, 5'd7, 1'b0, 1'b0, 1'b1);
    idle("lu_after", 1'b1);
    drive("lu_rt_match", 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b1);
    drive("lu_r0", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive("lu_nomatch", 1'b0, 1'b1, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (ctrl_state !== 2'd0) begin
      n_errors++;
      $display("FAIL lu_state: got %0d expected 0", ctrl_state);
    end
  endtask

  task automatic test_branch_ready();
    drive("br_ready", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (ctrl_state !== 2'd0) begin
      n_errors++;
      $display("FAIL br_ready_state: got %0d expected 0", ctrl_state);
    end
    drive("jump_ready", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle("br_after", 1'b1);
  endtask

  task automatic test_branch_discard();
    drive("br_notready", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ctrl_state !== 2'd2) begin
        n_errors++;
        $display("FAIL discard_state%0d: got %0d expected 2", i, ctrl_state);
      end
      idle("discard_wait", 1'b0);
    end
    n_checks++;
    if (ctrl_state !== 2'd2) begin
      n_errors++;
      $display("FAIL discard_hold: got %0d expected 2", ctrl_state);
    end
    idle("discard_drop", 1'b1);
    n_checks++;
    if (ctrl_state !== 2'd0) begin
      n_errors++;
      $display("FAIL discard_exit: got %0d expected 0", ctrl_state);
    end
    idle("discard_resume", 1'b1);
  endtask

  task automatic test_lu_br_same();
    drive("lubr_stall", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
    drive("lubr_branch", 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
    idle("lubr_after", 1'b1);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 14; i++) idle("to_wait", 1'b0);
    n_checks++;
    if (timeout !== 1'b0 || ctrl_state !== 2'd1) begin
      n_errors++;
      $display("FAIL timeout_early: got to=%b st=%0d expected to=0 st=1", timeout, ctrl_state);
    end
    idle("to_wait15", 1'b0);
    n_checks++;
    if (timeout !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_rise: got %b expected 1", timeout);
    end
    for (int i = 0; i < 3; i++) idle("to_ready", 1'b1);
    n_checks++;
    if (timeout !== 1'b1 || ctrl_state !== 2'd0) begin
      n_errors++;
      $display("FAIL timeout_sticky: got to=%b st=%0d expected to=1 st=0", timeout, ctrl_state);
    end
    drive("to_clear", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_clear: got %b expected 0", timeout);
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 3; i++) idle("rw_wait", 1'b0);
    drive("rw_reset", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctrl_state !== 2'd0 || timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_wait: got st=%0d to=%b expected st=0 to=0", ctrl_state, timeout);
    end
    // Counter must restart from zero: 14 more not-ready cycles stay below the limit
    for (int i = 0; i < 14; i++) idle("rw_rewait", 1'b0);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_cnt_clear: got %b expected 0", timeout);
    end
    drive("br_in_discard", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    drive("rw_reset2", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle("rw_post", 1'b1);
  endtask

  task automatic test_perf();
`ifdef HAZARD_PERF_CNT_EN
    drive("pf_reset", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive("pf_stall1", 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1);
    idle("pf_gap", 1'b1);
    drive("pf_stall2", 1'b0, 1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1);
    drive("pf_flush", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    idle("pf_miss", 1'b0);
    n_checks++;
    if (stall_count !== 16'd2 || flush_count !== 16'd1 || wait_count !== 16'd1) begin
      n_errors++;
      $display("FAIL perf_counts: got stall=%0d flush=%0d wait=%0d expected 2/1/1",
               stall_count, flush_count, wait_count);
    end
    idle("pf_end", 1'b1);
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      logic       r;
      logic [4:0] a;
      logic [4:0] b;
      logic [4:0] c;
      r = ($urandom_range(0, 31) == 0);
      a = 5'($urandom_range(0, 3));
      b = 5'($urandom_range(0, 3));
      c = 5'($urandom_range(0, 3));
      drive("random", r, 1'($urandom_range(0, 1)), a, b, c,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) != 0));
    end
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
    br_taken = 1'b0; jump = 1'b0; rdy = 1'b1;
    m_state = 2'd0; m_cnt = 0; m_to = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch_ready();
    test_branch_discard();
    test_lu_br_same();
    test_timeout();
    test_reset_mid_wait();
    test_perf();
    test_back_to_back();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_fetch_hazard_ctrl.md
# mips_fetch_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Drives the PC write-enable, the IF/ID register's `IF_IDWrite` and `IF_FLUSH`, and the ID/EX control-bubble select. It arbitrates three stall and redirect sources each cycle: load-use hazards, taken branches/jumps resolved in ID, and a multi-cycle instruction memory with a ready handshake. It also tracks wrong-path fetches that are still in flight when a redirect occurs.

## Interface
- `WAIT_LIMIT`, 15: consecutive not-ready fetch cycles before `FetchTimeout` sets; legal range 1..255.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge
- `RST`  in  1  synchronous, active-high reset
- `ID_EX_MemRead`  in  1  instruction in EX is a load
- `ID_EX_Rt`  in  5  load destination register in EX
- `IF_ID_Rs`  in  5  source register of instruction in ID
- `IF_ID_Rt`  in  5  second source register of instruction in ID
- `BranchTaken`  in  1  branch in ID resolved taken
- `JumpID`  in  1  jump decoded in ID
- `IMemReady`  in  1  instruction memory returns valid word this cycle
- `PCWrite`  out  1  PC register load enable
- `IF_IDWrite`  out  1  IF/ID write enable
- `IF_FLUSH`  out  1  IF/ID instruction zeroing
- `ID_EX_Bubble`  out  1  zero ID/EX control fields
- `CtrlState`  out  2  FSM state: 0 RUN, 1 WAIT, 2 DISCARD
- `FetchTimeout`  out  1  sticky timeout flag

## Operation
- LU = `ID_EX_MemRead` & (`ID_EX_Rt` != 0) & (`ID_EX_Rt` == `IF_ID_Rs` | `ID_EX_Rt` == `IF_ID_Rt`).
- BR = `BranchTaken` | `JumpID`.
- Outputs are combinational from state and current inputs. Priority is RST > LU > BR > fetch status.
- **RST:** `PCWrite`=0, `IF_IDWrite`=1, `IF_FLUSH`=1, `ID_EX_Bubble`=1.
  - Next state RUN; wait counter 0; `FetchTimeout` 0.
- **LU (any state):** `PCWrite`=0, `IF_IDWrite`=0, `IF_FLUSH`=0, `ID_EX_Bubble`=1.
  - State holds.
  - BR is ignored this cycle; the branch re-evaluates next cycle.
- **BR, no LU (any state):** `PCWrite`=1, `IF_IDWrite`=1, `IF_FLUSH`=1, `ID_EX_Bubble`=0.
  - Next state DISCARD if `IMemReady`=0 (old fetch still outstanding), otherwise RUN.
- **RUN/WAIT, no LU/BR:**
  - `IMemReady`=1: `PCWrite`=1, `IF_IDWrite`=1, `IF_FLUSH`=0. Next state RUN.
  - `IMemReady`=0: `PCWrite`=0, `IF_IDWrite`=1, `IF_FLUSH`=1 (bubble into ID). Next state WAIT.
- **DISCARD, no LU/BR:** `PCWrite`=0, `IF_IDWrite`=1, `IF_FLUSH`=1.
  - `IMemReady`=1 means the returned word is wrong-path and is discarded. Next state RUN.
  - `IMemReady`=0: stay in DISCARD.
- `ID_EX_Bubble`=0 whenever LU=0 and RST=0.
- **Wait counter (8-bit, saturating at 255):**
  - Increments each cycle `IMemReady`=0.
  - Clears on a cycle with `IMemReady`=1.
  - When it equals `WAIT_LIMIT`, `FetchTimeout` sets; it stays set until RST.

## Timing
- Control outputs have zero-cycle latency from inputs.
- State, counters and flag update at the CLK edge.
- A load-use stall lasts exactly 1 cycle when the bubble clears `ID_EX_MemRead`.
- A redirect with ready memory costs 1 flushed slot.
- A redirect with memory not ready costs 1 slot plus the DISCARD cycles plus the target fetch latency.
- RST asserted mid-wait or mid-discard discards all pending state at that edge. The first post-reset fetch starts in RUN.
- `FetchTimeout` rises on the edge where the counter transitions to `WAIT_LIMIT` (the WAIT_LIMIT-th consecutive not-ready cycle).

## Configuration
- `HAZARD_PERF_CNT_EN` defined: adds three output ports, each 16-bit, saturating, and reset to 0.
  - `StallCount`: LU cycles.
  - `FlushCount`: BR cycles that are not LU.
  - `WaitCount`: cycles with `IMemReady`=0.
- `HAZARD_PERF_CNT_EN` undefined: these ports and registers are absent; all other behaviour is identical.

## Test plan
- Load `lw $2` in EX, ID reads Rs=2, `IMemReady`=1 → one cycle of `PCWrite`=0, `IF_IDWrite`=0, `ID_EX_Bubble`=1, then normal flow. With `ID_EX_Rt`=0 → no stall.
- `BranchTaken`=1 with `IMemReady`=1 → `PCWrite`=1, `IF_FLUSH`=1, `CtrlState` stays 0.
- Same branch with `IMemReady`=0 for 3 cycles → DISCARD for 3 cycles with `PCWrite`=0, ready word flushed, then RUN.
- LU and BR in the same cycle → stall outputs only; branch honoured the next cycle.
- `IMemReady`=0 for 15 cycles with default `WAIT_LIMIT` → `FetchTimeout`=1 from that edge, held after ready returns, cleared only by RST.
- RST during WAIT → `CtrlState`=0, `FetchTimeout`=0. With `HAZARD_PERF_CNT_EN`: 2 stalls and 1 flush → `StallCount`=2, `FlushCount`=1.
